gin_scatter: RTL and testbench
==============================

Name: gin_scatter

Overview:
- Input-side counterpart of the gather/output network. Accepts tagged words from the host/buffer side, queues them, and multicasts each word to every PE whose scan-loaded (row, col) ID matches the word's tags.
- Delivers each word to all matching PEs in the same cycle, using an all-or-nothing ready handshake.
- Sits between the global buffer write port and the PE array input ports, on the single core clock.

Parameters:
- DATA_WIDTH, 64, payload width.
- ROW_TAG_WIDTH, 4, row tag/ID width.
- COL_TAG_WIDTH, 4, column tag/ID width.
- NUM_OF_ROWS, 12, PE rows.
- NUM_OF_COLS, 14, PE columns.
- FIFO_DEPTH, 16, entries in the input queue; power of 2, minimum 2.
- CNT_WIDTH, 16, width of the delivered/dropped counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  host write request
- row_tag  in  ROW_TAG_WIDTH  destination row tag
- col_tag  in  COL_TAG_WIDTH  destination column tag
- data_in  in  DATA_WIDTH  payload
- full  out  1  queue full; a write while full is ignored
- empty  out  1  queue and head both empty
- data_out  out  DATA_WIDTH  broadcast payload to all PEs
- enable_out  out  [0:NUM_OF_COLS-1] x [0:NUM_OF_ROWS-1]  per-PE write strobe
- ready_in  in  [0:NUM_OF_COLS-1] x [0:NUM_OF_ROWS-1]  per-PE can-accept
- se_id  in  1  ID scan enable
- si_id  in  1  ID scan in
- so_id  out  1  ID scan out
- delivered_cnt  out  CNT_WIDTH  words delivered, saturating
- dropped_cnt  out  CNT_WIDTH  words with zero matches, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count := 0; head_valid := 0; FSM := IDLE.
  - ID chain := all ones; counters := 0.
  - Outputs: full=0, empty=1, enable_out all 0, data_out=0, so_id=0.
- Reset applied mid-transfer discards all queued words. There is no partial-delivery state.
- Queue:
  - Stores {col_tag, row_tag, data}. A write is accepted iff wr_en & ~full.
  - full is registered and reflects occupancy == FIFO_DEPTH.
  - A pop in the same cycle does not free space for a write in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Head register: loads from the queue when head_valid=0 or the head is consumed this cycle. This keeps throughput at 1 word/cycle.
- ID chain:
  - Shift register of NUM_OF_ROWS*ROW_TAG_WIDTH + NUM_OF_ROWS*NUM_OF_COLS*COL_TAG_WIDTH bits.
  - Shifts one bit per cycle while se_id=1, si_id entering the LSB. so_id is the MSB.
  - Field order from MSB down: row IDs r=0..NUM_OF_ROWS-1, then col IDs r-major, c-minor. Each field is MSB first.
- Match logic:
  - match[r][c] = head_valid & (id_row[r]==head.row) & (id_col[r][c]==head.col).
  - fire = state ISSUE & |match & all(ready_in | ~match).
- FSM:
  - IDLE: move to ISSUE when head_valid and se_id=0.
  - ISSUE:
    - If |match==0: drop the head in one cycle; dropped_cnt+1; enable_out stays 0.
    - Else wait, holding data_out stable, until fire.
    - On fire: enable_out = match for exactly that cycle; consume the head; delivered_cnt+1.
    - Next state is ISSUE if the next head is valid, else IDLE.
  - se_id=1: forces state HOLD, with no issue and no drop. Writes are still accepted.
  - HOLD: returns to ISSUE/IDLE on the first cycle with se_id=0, using the freshly shifted IDs.
- enable_out is combinational from fire/match. data_out is the head payload and is valid whenever head_valid.
- Latency: a word written at edge E0 into an empty block can produce enable_out in the cycle after E2, assuming ready.
- Counters saturate at all ones and never wrap.

Decomposition:
- Package gin_pkg:
  - tag struct {col, row}
  - FSM enum {IDLE, ISSUE, HOLD}
  - localparams for ID chain length and field offsets
- Sub-module gin_sync_fifo: parameterised single-clock FIFO with registered full/empty, used for the tagged-word queue.
- Match/fire logic and the scan chain stay in gin_scatter.

Test Plan:
- IDs scanned so row r has ID r and all cols in row 3 have ID 5. Write {row=3,col=5,data=0xA5}, all ready → enable_out row 3 all 1 for one cycle, data_out=0xA5, delivered_cnt=1.
- Multicast stall: same word, but PE(3,7) has ready_in=0 for 10 cycles → enable_out stays 0 and data_out holds 0xA5. When ready rises, there is a single 14-PE strobe.
- Write {row=15,col=15} with no matching ID → no enable, dropped_cnt=1. The next queued word issues the following cycle.
- Fill FIFO_DEPTH=16 words with all ready_in=0 → full=1. A 17th write is ignored. Releasing ready delivers exactly 16 words in order, and full deasserts after the first pop.
- Assert se_id mid-stream with queued words → no enable_out while se_id=1. Shift in new IDs; so_id emits the old chain MSB-first. After se_id=0, delivery resumes using the new IDs.
- Drive reset low while the head is waiting for ready → enable_out=0, empty=1, counters=0 asynchronously. No word is delivered after release.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared types and helpers for the gin_scatter input network.
// Holds the tag struct, the issue FSM encoding and the ID scan-chain layout
// helpers (chain length and per-field MSB positions).
package gin_pkg;

    localparam int TAG_ROW_W = 4;
    localparam int TAG_COL_W = 4;
    localparam int DEF_ROWS  = 12;
    localparam int DEF_COLS  = 14;

    // Tag widths are fixed here; the top-level tag width parameters must match.
    typedef struct packed {
        logic [TAG_COL_W-1:0] col;
        logic [TAG_ROW_W-1:0] row;
    } gin_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } gin_state_t;

    function automatic int id_chain_len(input int rows, input int cols, input int rw, input int cw);
        return rows * rw + rows * cols * cw;
    endfunction

    // Row IDs sit at the top of the chain, row 0 first.
    function automatic int row_id_msb(input int len, input int r, input int rw);
        return len - 1 - r * rw;
    endfunction

    // Column IDs follow the row IDs, row-major then column-minor.
    function automatic int col_id_msb(input int len, input int rows, input int cols,
                                      input int rw, input int cw, input int r, input int c);
        return len - 1 - rows * rw - (r * cols + c) * cw;
    endfunction

    localparam int DEF_ID_CHAIN_LEN = id_chain_len(DEF_ROWS, DEF_COLS, TAG_ROW_W, TAG_COL_W);

endpackage

// File: rtl/gin_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Ports: clk, reset (async active-low), wr_en/wr_data (write, ignored when
// full), rd_en/rd_data (rd_data shows the oldest entry, pop ignored when
// empty), full, empty.
module gin_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gin_scatter.sv
// Input-side scatter network: queues tagged words from the buffer side and
// multicasts each one to every PE whose scan-loaded (row, col) ID matches.
// Ports: clk, reset (async active-low); wr_en/row_tag/col_tag/data_in host
// write, full/empty status; data_out + enable_out[col][row] to the PE array,
// ready_in[col][row] back; se_id/si_id/so_id ID scan chain;
// delivered_cnt/dropped_cnt saturating statistics.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no head word waiting
//   ST_ISSUE | head word present: drop it if nothing matches, else wait
//            | until every matching PE is ready and strobe them all at once
//   ST_HOLD  | ID chain shifting; no issue and no drop
module gin_scatter
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = TAG_ROW_W,
    parameter int COL_TAG_WIDTH = TAG_COL_W,
    parameter int NUM_OF_ROWS   = 12,
    parameter int NUM_OF_COLS   = 14,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    wr_en,
    input  logic [ROW_TAG_WIDTH-1:0]                row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                col_tag,
    input  logic [DATA_WIDTH-1:0]                   data_in,
    output logic                                    full,
    output logic                                    empty,
    output logic [DATA_WIDTH-1:0]                   data_out,
    output logic [0:NUM_OF_COLS-1][0:NUM_OF_ROWS-1] enable_out,
    input  logic [0:NUM_OF_COLS-1][0:NUM_OF_ROWS-1] ready_in,
    input  logic                                    se_id,
    input  logic                                    si_id,
    output logic                                    so_id,
    output logic [CNT_WIDTH-1:0]                    delivered_cnt,
    output logic [CNT_WIDTH-1:0]                    dropped_cnt
);
    localparam int ID_LEN = id_chain_len(NUM_OF_ROWS, NUM_OF_COLS, ROW_TAG_WIDTH, COL_TAG_WIDTH);
    localparam int TAG_W  = COL_TAG_WIDTH + ROW_TAG_WIDTH;
    localparam int QW     = TAG_W + DATA_WIDTH;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

    gin_state_t                              state;
    logic                                    q_rd;
    logic                                    q_full;
    logic                                    q_empty;
    logic [QW-1:0]                           q_rd_data;
    logic                                    wr_accept;
    gin_tag_t                                head_tag;
    logic [DATA_WIDTH-1:0]                   head_data;
    logic                                    head_valid;
    logic [OCC_W-1:0]                        occ;
    logic [OCC_W-1:0]                        occ_nxt;
    logic [ID_LEN-1:0]                       id_chain;
    logic [ROW_TAG_WIDTH-1:0]                id_row [NUM_OF_ROWS];
    logic [COL_TAG_WIDTH-1:0]                id_col [NUM_OF_ROWS][NUM_OF_COLS];
    logic [0:NUM_OF_COLS-1][0:NUM_OF_ROWS-1] match;
    logic                                    any_match;
    logic                                    all_ready;
    logic                                    issue_ok;
    logic                                    fire;
    logic                                    drop;
    logic                                    consume;

    // full covers the head register as well as the queue, so the block holds
    // at most FIFO_DEPTH words in total.
    assign wr_accept = wr_en & ~full & ~q_full;
    assign q_rd      = ~head_valid | consume;
    assign empty     = q_empty & ~head_valid;
    assign data_out  = head_data;

    gin_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_data ({col_tag, row_tag, data_in}),
        .rd_en   (q_rd),
        .rd_data (q_rd_data),
        .full    (q_full),
        .empty   (q_empty)
    );

    for (genvar r = 0; r < NUM_OF_ROWS; r++) begin : g_row
        assign id_row[r] = id_chain[row_id_msb(ID_LEN, r, ROW_TAG_WIDTH) -: ROW_TAG_WIDTH];
        for (genvar c = 0; c < NUM_OF_COLS; c++) begin : g_col
            assign id_col[r][c] = id_chain[col_id_msb(ID_LEN, NUM_OF_ROWS, NUM_OF_COLS,
                                                      ROW_TAG_WIDTH, COL_TAG_WIDTH, r, c)
                                           -: COL_TAG_WIDTH];
        end
    end

    always_comb begin
        match = '0;
        for (int r = 0; r < NUM_OF_ROWS; r++) begin
            for (int c = 0; c < NUM_OF_COLS; c++) begin
                match[c][r] = head_valid && (id_row[r] == head_tag.row)
                              && (id_col[r][c] == head_tag.col);
            end
        end
    end

    // se_id gates issue directly so a half-shifted chain can never strobe or drop.
    assign any_match  = |match;
    assign all_ready  = &(ready_in | ~match);
    assign issue_ok   = (state == ST_ISSUE) && !se_id && head_valid;
    assign fire       = issue_ok && any_match && all_ready;
    assign drop       = issue_ok && !any_match;
    assign consume    = fire | drop;
    assign enable_out = fire ? match : '0;

    always_comb begin
        occ_nxt = occ;
        if (wr_accept) occ_nxt = occ_nxt + OCC_W'(1);
        if (consume)   occ_nxt = occ_nxt - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ  <= '0;
            full <= 1'b0;
        end else begin
            occ  <= occ_nxt;
            full <= (occ_nxt == OCC_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_valid <= 1'b0;
            head_tag   <= '0;
            head_data  <= '0;
        end else if (q_rd && !q_empty) begin
            head_valid <= 1'b1;
            head_tag   <= q_rd_data[DATA_WIDTH +: TAG_W];
            head_data  <= q_rd_data[DATA_WIDTH-1:0];
        end else if (consume) begin
            head_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (se_id) begin
            state <= ST_HOLD;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: state <= head_valid ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: begin
                    // After a consume the head reloads only if the queue has a word.
                    if (consume) state <= q_empty ? ST_IDLE : ST_ISSUE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // so_id is registered: it shows the bit that left the chain MSB on the last shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_chain <= '1;
            so_id    <= 1'b0;
        end else if (se_id) begin
            id_chain <= {id_chain[ID_LEN-2:0], si_id};
            so_id    <= id_chain[ID_LEN-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delivered_cnt <= '0;
            dropped_cnt   <= '0;
        end else begin
            if (fire && delivered_cnt != '1) delivered_cnt <= delivered_cnt + CNT_WIDTH'(1);
            if (drop && dropped_cnt != '1)   dropped_cnt   <= dropped_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_gin_scatter.sv
module tb_gin_scatter;
    localparam int NR = 12;
    localparam int NC = 14;
    localparam int L  = NR * 4 + NR * NC * 4;

    typedef logic [0:NC-1][0:NR-1] mask_t;
    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [63:0] data;
    } word_t;

    logic        clk, reset, wr_en, full, empty, se_id, si_id, so_id;
    logic [3:0]  row_tag, col_tag;
    logic [63:0] data_in, data_out;
    mask_t       enable_out, ready_in;
    logic [15:0] delivered_cnt, dropped_cnt;

    gin_scatter #(
        .DATA_WIDTH(64), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4),
        .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .FIFO_DEPTH(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .row_tag(row_tag), .col_tag(col_tag),
        .data_in(data_in), .full(full), .empty(empty), .data_out(data_out),
        .enable_out(enable_out), .ready_in(ready_in), .se_id(se_id), .si_id(si_id),
        .so_id(so_id), .delivered_cnt(delivered_cnt), .dropped_cnt(dropped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: pending words, current PE IDs, expected counters
    word_t      mq[$];
    logic [3:0] m_row [NR];
    logic [3:0] m_col [NR][NC];
    logic [L-1:0] cur_chain;
    int n_checks = 0, n_err = 0;
    int exp_deliv = 0, exp_drop = 0, n_strobes = 0;
    bit rand_ready = 0;

    function automatic mask_t calc_mask(input logic [3:0] row, input logic [3:0] col);
        mask_t m = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (m_row[r] == row && m_col[r][c] == col) m[c][r] = 1'b1;
        return m;
    endfunction

    function automatic logic [L-1:0] build_chain();
        logic [L-1:0] v = '0;
        for (int r = 0; r < NR; r++) v[L-1-r*4 -: 4] = m_row[r];
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) v[L-1-NR*4-(r*NC+c)*4 -: 4] = m_col[r][c];
        return v;
    endfunction

    function automatic mask_t rand_mask();
        mask_t m;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) m[c][r] = ($urandom_range(0, 15) != 0);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every strobe must be the next word that matches under the model IDs
    word_t mon_w;
    mask_t mon_m;
    bit    mon_got;
    always @(negedge clk) begin
        if (reset === 1'b1 && enable_out !== '0) begin
            mon_got = 0;
            while (mq.size() > 0 && !mon_got) begin
                mon_w = mq.pop_front();
                mon_m = calc_mask(mon_w.row, mon_w.col);
                if (mon_m == '0) exp_drop++;
                else mon_got = 1;
            end
            n_checks++;
            if (!mon_got) begin
                n_err++;
                $display("FAIL strobe_unexpected: enable_out=%h with no word pending", enable_out);
            end else begin
                n_strobes++;
                exp_deliv++;
                if (enable_out !== mon_m || data_out !== mon_w.data) begin
                    n_err++;
                    $display("FAIL strobe: enable_out=%h data_out=%h expected enable_out=%h data_out=%h",
                             enable_out, data_out, mon_m, mon_w.data);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready_in = rand_mask();
        end
    end

    task automatic wr(input logic [3:0] row, input logic [3:0] col, input logic [63:0] d,
                      input bit accept);
        word_t w;
        wr_en = 1'b1; row_tag = row; col_tag = col; data_in = d;
        w.row = row; w.col = col; w.data = d;
        if (accept) mq.push_back(w);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic scan(input logic [L-1:0] nv, input string name);
        int bad_so = 0, bad_en = 0;
        se_id = 1'b1;
        for (int i = L - 1; i >= 0; i--) begin
            si_id = nv[i];
            @(posedge clk); #1;
            if (so_id !== cur_chain[i]) bad_so++;
            if (enable_out !== '0) bad_en++;
        end
        se_id = 1'b0; si_id = 1'b0;
        check({name, "_so_bits_bad"}, bad_so, 0);
        check({name, "_enable_while_scan"}, bad_en, 0);
        cur_chain = nv;
    endtask

    task automatic settle(input string name);
        int k = 0, left = 0;
        word_t w;
        while (empty !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        check({name, "_drain_timeout"}, (k >= 3000), 0);
        @(negedge clk);
        while (mq.size() > 0) begin
            w = mq.pop_front();
            if (calc_mask(w.row, w.col) == '0) exp_drop++;
            else left++;
        end
        check({name, "_undelivered"}, left, 0);
        check({name, "_delivered_cnt"}, delivered_cnt, exp_deliv);
        check({name, "_dropped_cnt"}, dropped_cnt, exp_drop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, k, n;
        logic [3:0] rr, cc;
        reset = 1'b0; wr_en = 0; row_tag = 0; col_tag = 0; data_in = 0;
        se_id = 0; si_id = 0; ready_in = '1;
        cur_chain = '1;
        #12;
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_enable", (enable_out != '0), 0);
        check("rst_data_out", data_out, 0);
        check("rst_so_id", so_id, 0);
        check("rst_delivered", delivered_cnt, 0);
        check("rst_dropped", dropped_cnt, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // IDs: row r -> r; cols of row 3 -> 5, other cols -> c
        for (int r = 0; r < NR; r++) begin
            m_row[r] = 4'(r);
            for (int c = 0; c < NC; c++) m_col[r][c] = (r == 3) ? 4'd5 : 4'(c);
        end
        scan(build_chain(), "scan_init");

        // single multicast with latency check
        wr(4'd3, 4'd5, 64'hA5, 1);
        @(negedge clk); check("lat_e0_enable", (enable_out != '0), 0);
        @(negedge clk); check("lat_e1_enable", (enable_out != '0), 0);
        @(negedge clk); check("lat_e2_enable", (enable_out != '0), 1);
        settle("single");

        // multicast stall on PE(3,7)
        ready_in[7][3] = 1'b0;
        s0 = n_strobes;
        wr(4'd3, 4'd5, 64'hA5, 1);
        k = 0; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (enable_out !== '0) k++;
            if (i >= 2 && data_out !== 64'hA5) n++;
        end
        check("stall_enable_cycles", k, 0);
        check("stall_data_bad_cycles", n, 0);
        @(posedge clk); #1; ready_in[7][3] = 1'b1;
        settle("stall");
        check("stall_strobe_count", n_strobes - s0, 1);

        // unmatched word dropped in one cycle, next word issues right after
        wr(4'd15, 4'd15, 64'h1111, 1);
        wr(4'd3, 4'd5, 64'h5A, 1);
        @(negedge clk);
        @(negedge clk); check("drop_cycle_enable", (enable_out != '0), 0);
        @(negedge clk); check("after_drop_enable", (enable_out != '0), 1);
        settle("drop");

        // fill to full, 17th write ignored, drain in order
        ready_in = '0;
        for (int i = 0; i < 16; i++) begin
            rr = 4'($urandom_range(0, NR - 1));
            cc = (rr == 4'd3) ? 4'd5 : 4'($urandom_range(0, NC - 1));
            wr(rr, cc, {32'hF000_0000, 32'(i)}, 1);
        end
        check("full_after_16", full, 1);
        wr(4'd3, 4'd5, 64'hDEAD, 0);
        check("full_after_17th", full, 1);
        ready_in = '1;
        k = 0;
        while (enable_out === '0 && k < 50) begin @(negedge clk); k++; end
        check("full_first_strobe_timeout", (k >= 50), 0);
        check("full_at_first_pop", full, 1);
        @(negedge clk); check("full_after_first_pop", full, 0);
        settle("fill");

        // rescan mid-stream with queued words
        ready_in = '0;
        for (int i = 0; i < 5; i++)
            wr(4'($urandom_range(0, NR - 1)), 4'($urandom_range(0, NC - 1)), 64'($urandom), 1);
        for (int r = 0; r < NR; r++) begin
            m_row[r] = 4'(NR - 1 - r);
            for (int c = 0; c < NC; c++) m_col[r][c] = 4'((r + c) % NC);
        end
        se_id = 1'b1; ready_in = '1;
        scan(build_chain(), "scan_mid");
        settle("rescan");

        // randomized traffic with random backpressure
        rand_ready = 1;
        for (int round = 0; round < 4; round++) begin
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                wr(4'($urandom_range(0, 13)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            settle($sformatf("rand%0d", round));
        end
        rand_ready = 0;
        @(posedge clk); #2; ready_in = '0;

        // asynchronous reset while the head waits for ready
        wr(m_row[0], m_col[0][0], 64'hBEEF, 1);
        repeat (5) @(posedge clk);
        #2; reset = 1'b0;
        #1;
        check("arst_enable", (enable_out != '0), 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_data_out", data_out, 0);
        check("arst_delivered", delivered_cnt, 0);
        check("arst_dropped", dropped_cnt, 0);
        mq.delete();
        exp_deliv = 0; exp_drop = 0;
        for (int r = 0; r < NR; r++) begin
            m_row[r] = 4'hF;
            for (int c = 0; c < NC; c++) m_col[r][c] = 4'hF;
        end
        cur_chain = '1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ready_in = '1;
        s0 = n_strobes;
        repeat (10) @(negedge clk);
        check("arst_no_strobe", n_strobes - s0, 0);
        check("arst_delivered_after", delivered_cnt, 0);
        check("arst_empty_after", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
